// File: rtl/restorer_pkg.sv
// Shared types and helpers for the NAND bundle restorer: FSM state encoding,
// default counter width and a width-parameterised popcount.
package restorer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned COUNT_W_DEF = 16;
    localparam int unsigned POP_MAX_W   = 64;

    // Counts set bits among the low `width` bits; callers zero-extend into POP_MAX_W.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v,
                                             input int unsigned         width);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            if (i < width && v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/nand_bundle_restorer_vote.sv
// bundle_threshold_vote: combinational threshold vote over a redundant bundle.
// Popcount at/above HI_THRESH votes 1, at/below LO_THRESH votes 0, else undecided.
module bundle_threshold_vote
    import restorer_pkg::*;
#(
    parameter int unsigned BUNDLE_WIDTH = 8,
    parameter int unsigned HI_THRESH    = 6,
    parameter int unsigned LO_THRESH    = 2
) (
    input  logic [BUNDLE_WIDTH-1:0] bundle,
    output logic                    vote,
    output logic                    undecided
);

    int unsigned pc;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        vote      = 1'b0;
        undecided = 1'b0;
        pc        = popcount(POP_MAX_W'(bundle), BUNDLE_WIDTH);
        if (pc >= HI_THRESH) begin
            vote = 1'b1;
        end else if (pc > LO_THRESH) begin
            undecided = 1'b1;
        end
    end

endmodule

// File: rtl/nand_bundle_restorer.sv
// Restores a redundant NAND bundle to one registered value and measures error counts
// over a started window. Optional first-error capture: RESTORER_FIRST_ERR_CAPTURE_EN.
module nand_bundle_restorer
    import restorer_pkg::*;
#(
    parameter int unsigned BUNDLE_WIDTH = 8,
    parameter int unsigned HI_THRESH    = 6,
    parameter int unsigned LO_THRESH    = 2,
    parameter int unsigned COUNT_W      = COUNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [BUNDLE_WIDTH-1:0] bundle_i,
    input  logic                    bundle_valid_i,
    input  logic                    golden_i,
    input  logic                    start_i,
    input  logic [COUNT_W-1:0]      window_len_i,
    output logic                    z_o,
    output logic                    z_valid_o,
    output logic                    undecided_o,
    output logic [COUNT_W-1:0]      err_count_o,
    output logic [COUNT_W-1:0]      undecided_count_o,
    output logic [COUNT_W-1:0]      sample_count_o,
    output logic                    busy_o,
`ifdef RESTORER_FIRST_ERR_CAPTURE_EN
    output logic [COUNT_W-1:0]      first_err_idx_o,
    output logic                    first_err_vld_o,
`endif
    output logic                    done_o
);

    state_t             state;
    logic [COUNT_W-1:0] len_q;
    logic [COUNT_W-1:0] err_q;
    logic [COUNT_W-1:0] undec_q;
    logic [COUNT_W-1:0] samp_q;
    logic               z_q;
    logic               z_valid_q;
    logic               undec_flag_q;
    logic               vote;
    logic               vote_undecided;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    bundle_threshold_vote #(
        .BUNDLE_WIDTH (BUNDLE_WIDTH),
        .HI_THRESH    (HI_THRESH),
        .LO_THRESH    (LO_THRESH)
    ) u_vote (
        .bundle    (bundle_i),
        .vote      (vote),
        .undecided (vote_undecided)
    );

    // An undecided sample keeps the last restored value rather than guessing.
    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_q          <= 1'b0;
            z_valid_q    <= 1'b0;
            undec_flag_q <= 1'b0;
        end else begin
            z_valid_q <= bundle_valid_i;
            if (bundle_valid_i) begin
                if (vote_undecided) begin
                    undec_flag_q <= 1'b1;
                end else begin
                    z_q          <= vote;
                    undec_flag_q <= 1'b0;
                end
            end
        end
    end

    // NOTE: all counters and the captured length reset asynchronously so a mid-window reset leaves no partial result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            len_q   <= '0;
            err_q   <= '0;
            undec_q <= '0;
            samp_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        len_q   <= window_len_i;
                        err_q   <= '0;
                        undec_q <= '0;
                        samp_q  <= '0;
                        state   <= (window_len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (bundle_valid_i) begin
                        samp_q <= sat_inc(samp_q);
                        if (vote_undecided) begin
                            undec_q <= sat_inc(undec_q);
                        end else if (vote != golden_i) begin
                            err_q <= sat_inc(err_q);
                        end
                        // Saturation of sample_count also ends an all-ones window.
                        if (sat_inc(samp_q) == len_q) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESTORER_FIRST_ERR_CAPTURE_EN
    logic [COUNT_W-1:0] first_idx_q;
    logic               first_vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
        end else if (start_i && state != RUN) begin
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
        end else if (state == RUN && bundle_valid_i && !vote_undecided
                     && vote != golden_i && !first_vld_q) begin
            first_idx_q <= samp_q;
            first_vld_q <= 1'b1;
        end
    end

    assign first_err_idx_o = first_idx_q;
    assign first_err_vld_o = first_vld_q;
`endif

    assign z_o               = z_q;
    assign z_valid_o         = z_valid_q;
    assign undecided_o       = undec_flag_q;
    assign err_count_o       = err_q;
    assign undecided_count_o = undec_q;
    assign sample_count_o    = samp_q;
    assign busy_o            = (state == RUN);
    assign done_o            = (state == DONE);

endmodule

// File: tb/tb_nand_bundle_restorer.sv
// Self-checking bench for nand_bundle_restorer: restore path via scoreboard,
// window counters, zero-length window, saturation (COUNT_W=4 instance), mid-window reset.
module tb_nand_bundle_restorer;

    localparam int BW = 8;
    localparam int CW = 16;
    localparam int SW = 4;

    typedef struct packed {
        logic z;
        logic und;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [BW-1:0] bundle = '0;
    logic          valid = 1'b0;
    logic          golden = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] window_len = '0;
    logic          start_s = 1'b0;
    logic [SW-1:0] window_len_s = '0;

    logic          z, z_valid, und, busy, done;
    logic [CW-1:0] err_cnt, und_cnt, samp_cnt;
    logic          s_z, s_z_valid, s_und, s_busy, s_done;
    logic [SW-1:0] s_err_cnt, s_und_cnt, s_samp_cnt;
`ifdef RESTORER_FIRST_ERR_CAPTURE_EN
    logic [CW-1:0] fe_idx;
    logic          fe_vld;
    logic [SW-1:0] s_fe_idx;
    logic          s_fe_vld;
`endif

    exp_t sb[$];
    logic model_z = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    nand_bundle_restorer #(.BUNDLE_WIDTH(BW), .HI_THRESH(6), .LO_THRESH(2), .COUNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .bundle_i(bundle), .bundle_valid_i(valid),
        .golden_i(golden), .start_i(start), .window_len_i(window_len),
        .z_o(z), .z_valid_o(z_valid), .undecided_o(und), .err_count_o(err_cnt),
        .undecided_count_o(und_cnt), .sample_count_o(samp_cnt), .busy_o(busy),
`ifdef RESTORER_FIRST_ERR_CAPTURE_EN
        .first_err_idx_o(fe_idx), .first_err_vld_o(fe_vld),
`endif
        .done_o(done)
    );

    nand_bundle_restorer #(.BUNDLE_WIDTH(BW), .HI_THRESH(6), .LO_THRESH(2), .COUNT_W(SW)) dut_s (
        .clk(clk), .reset_n(reset_n), .bundle_i(bundle), .bundle_valid_i(valid),
        .golden_i(golden), .start_i(start_s), .window_len_i(window_len_s),
        .z_o(s_z), .z_valid_o(s_z_valid), .undecided_o(s_und), .err_count_o(s_err_cnt),
        .undecided_count_o(s_und_cnt), .sample_count_o(s_samp_cnt), .busy_o(s_busy),
`ifdef RESTORER_FIRST_ERR_CAPTURE_EN
        .first_err_idx_o(s_fe_idx), .first_err_vld_o(s_fe_vld),
`endif
        .done_o(s_done)
    );

    // Drives one valid sample (optionally with start), then checks the restored output against the scoreboard.
    task automatic send(input logic [BW-1:0] b, input logic g, input logic st);
        exp_t e;
        int   pc;
        pc = $countones(b);
        if (pc >= 6) begin
            model_z = 1'b1;
            e = '{z: 1'b1, und: 1'b0};
        end else if (pc <= 2) begin
            model_z = 1'b0;
            e = '{z: 1'b0, und: 1'b0};
        end else begin
            e = '{z: model_z, und: 1'b1};
        end
        sb.push_back(e);
        bundle = b; golden = g; valid = 1'b1; start = st;
        @(posedge clk); #1;
        valid = 1'b0; start = 1'b0;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty bundle=%h", b);
        end else begin
            e = sb.pop_front();
            if ({z_valid, z, und} !== {1'b1, e.z, e.und})
                $display("FAIL restore bundle=%h got valid/z/und=%b%b%b want 1%b%b",
                         b, z_valid, z, und, e.z, e.und);
            else n_pass++;
        end
    endtask

    task automatic pulse_start(input logic [CW-1:0] len);
        window_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_counts(input string name, input logic [CW-1:0] e_err,
                                input logic [CW-1:0] e_und, input logic [CW-1:0] e_samp,
                                input logic e_busy, input logic e_done);
        n_checks++;
        if ({err_cnt, und_cnt, samp_cnt, busy, done} !== {e_err, e_und, e_samp, e_busy, e_done})
            $display("FAIL %s got err=%0d und=%0d samp=%0d busy=%b done=%b want err=%0d und=%0d samp=%0d busy=%b done=%b",
                     name, err_cnt, und_cnt, samp_cnt, busy, done, e_err, e_und, e_samp, e_busy, e_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_counts("reset_counters", 0, 0, 0, 1'b0, 1'b0);
        n_checks++;
        if ({z, z_valid, und, s_busy, s_done, s_samp_cnt} !== '0)
            $display("FAIL reset_outputs got z/zv/und=%b%b%b s_busy=%b s_done=%b s_samp=%0d want all 0",
                     z, z_valid, und, s_busy, s_done, s_samp_cnt);
        else n_pass++;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_restore();
        send(8'hFF, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if ({z_valid, z, und} !== 3'b011)
            $display("FAIL restore_hold got valid/z/und=%b%b%b want 011", z_valid, z, und);
        else n_pass++;
        send(8'h01, 1'b0, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        send(8'hFC, 1'b1, 1'b0);
        check_counts("idle_no_count", 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_window();
        pulse_start(4);
        check_counts("window_started", 0, 0, 0, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        send(8'h07, 1'b0, 1'b0);
        check_counts("window_mid", 1, 1, 3, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check_counts("window_done", 1, 1, 4, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_counts("window_hold", 1, 1, 4, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        window_len = 3;
        send(8'hFF, 1'b0, 1'b1);
        check_counts("start_sample_ignored", 0, 0, 0, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        pulse_start(100);
        check_counts("start_in_run_ignored", 1, 0, 1, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        check_counts("b2b_done", 1, 0, 3, 1'b0, 1'b1);
        send(8'h00, 1'b1, 1'b0);
        check_counts("done_stable", 1, 0, 3, 1'b0, 1'b1);
    endtask

    task automatic test_zero_len();
        pulse_start(0);
        check_counts("zero_len", 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        window_len_s = 4'hF; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int i = 0; i < 20; i++) send(8'hFF, 1'b0, 1'b0);
        n_checks++;
        if ({s_err_cnt, s_und_cnt, s_samp_cnt, s_busy, s_done} !== {4'hF, 4'h0, 4'hF, 1'b0, 1'b1})
            $display("FAIL saturation got err=%0d und=%0d samp=%0d busy=%b done=%b want err=15 und=0 samp=15 busy=0 done=1",
                     s_err_cnt, s_und_cnt, s_samp_cnt, s_busy, s_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse_start(10);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check_counts("mid_before_reset", 0, 0, 2, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_counts("mid_reset", 0, 0, 0, 1'b0, 1'b0);
        model_z = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_counts("after_reset_idle", 0, 0, 0, 1'b0, 1'b0);
    endtask

`ifdef RESTORER_FIRST_ERR_CAPTURE_EN
    task automatic test_first_err();
        pulse_start(5);
        n_checks++;
        if ({fe_vld, fe_idx} !== '0)
            $display("FAIL first_err_clear got vld=%b idx=%0d want 0 0", fe_vld, fe_idx);
        else n_pass++;
        send(8'hFF, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({fe_vld, fe_idx, done} !== {1'b1, 16'd2, 1'b1})
            $display("FAIL first_err_idx got vld=%b idx=%0d done=%b want 1 2 1", fe_vld, fe_idx, done);
        else n_pass++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_restore();
        test_window();
        test_back_to_back();
        test_zero_len();
        test_saturation();
        test_reset_mid();
`ifdef RESTORER_FIRST_ERR_CAPTURE_EN
        test_first_err();
`endif
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
